// File: rtl/cic_pkg.sv
// Shared CIC constants and helpers, used by the integrator, the comb decimator and their benches.
package cic_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int CIC_WIN = 16;
    localparam int CIC_WG  = 22;
    localparam int CIC_R   = 128;
    localparam int CIC_N   = 3;
    localparam int CIC_M   = 1;
    localparam int CIC_W   = CIC_WIN + CIC_WG;

endpackage

// File: rtl/cic_comb_dec_stage.sv
// One comb (differentiator) stage: y[n] = x[n] - x[n-M], advanced only on valid input.
module comb_stage #(
    parameter int W = 38,
    parameter int M = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                val_in,
    input  logic signed [W-1:0] x,
    output logic                val_out,
    output logic signed [W-1:0] y
);

    logic signed [W-1:0] dly [M];

    // Subtraction wraps modulo 2^W on purpose: it cancels integrator overflow upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_out <= 1'b0;
            y       <= '0;
            for (int i = 0; i < M; i++) dly[i] <= '0;
        end else begin
            val_out <= val_in;
            if (val_in) begin
                y      <= x - dly[M-1];
                dly[0] <= x;
                for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
            end
        end
    end

endmodule

// File: rtl/cic_comb_dec.sv
// CIC decimator back end: keep every R-th valid integrator sample, run N comb stages,
// then keep the Wout MSBs of the result.
module cic_comb_dec
    import cic_pkg::*;
#(
    parameter int Win  = CIC_WIN,
    parameter int Wg   = CIC_WG,
    parameter int R    = CIC_R,
    parameter int N    = CIC_N,
    parameter int M    = CIC_M,
    parameter int Wout = CIC_WIN,
    localparam int W   = Win + Wg
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   val_in,
    input  logic signed [W-1:0]    data_in,
    output logic                   val_out,
    output logic signed [Wout-1:0] data_out
);

    localparam int CNT_W = (clog2(R) < 1) ? 1 : clog2(R);

    function automatic logic signed [Wout-1:0] trunc_msb(input logic signed [W-1:0] v);
        return v[W-1 -: Wout];
    endfunction

    logic [CNT_W-1:0]    cnt;
    logic signed [W-1:0] dec_p0;
    logic                vld_p0;

    logic signed [W-1:0] comb_data [N+1];
    logic                comb_vld  [N+1];

    // Stage p0: decimation counter and capture register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            vld_p0 <= 1'b0;
            dec_p0 <= '0;
        end else begin
            vld_p0 <= 1'b0;
            if (val_in) begin
                if (cnt == CNT_W'(R - 1)) begin
                    cnt    <= '0;
                    vld_p0 <= 1'b1;
                    dec_p0 <= data_in;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign comb_data[0] = dec_p0;
    assign comb_vld[0]  = vld_p0;

    // Stages p1..pN: comb chain
    for (genvar g = 0; g < N; g++) begin : g_comb
        comb_stage #(.W(W), .M(M)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .val_in  (comb_vld[g]),
            .x       (comb_data[g]),
            .val_out (comb_vld[g+1]),
            .y       (comb_data[g+1])
        );
    end

    // Output stage: truncate and hold between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            val_out  <= 1'b0;
            data_out <= '0;
        end else begin
            val_out <= comb_vld[N];
            if (comb_vld[N]) data_out <= trunc_msb(comb_data[N]);
        end
    end

endmodule

// File: tb/tb_cic_comb_dec.sv
// Scoreboard bench for cic_comb_dec: small config (R=4,N=1,M=1) plus default config behind INT model.
module tb_cic_comb_dec;
    import cic_pkg::*;

    localparam int W = CIC_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                val_in = 1'b0;
    logic signed [W-1:0] data_in = '0;
    logic                val_out;
    logic signed [W-1:0] data_out;

    logic                def_val = 1'b0;
    logic signed [W-1:0] def_data = '0;
    logic                def_val_out;
    logic signed [15:0]  def_out;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cic_comb_dec #(.Win(16), .Wg(22), .R(4), .N(1), .M(1), .Wout(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .val_in   (val_in),
        .data_in  (data_in),
        .val_out  (val_out),
        .data_out (data_out)
    );

    cic_comb_dec u_def (
        .clk      (clk),
        .rst      (rst),
        .val_in   (def_val),
        .data_in  (def_data),
        .val_out  (def_val_out),
        .data_out (def_out)
    );

    typedef struct {
        logic signed [W-1:0] data;
        int                  at;
    } exp_t;

    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference: every 4th valid sample, output = sample - previous kept sample,
    // visible after the 2nd edge following the capture edge.
    int                  mcnt = 0;
    logic signed [W-1:0] prev = '0;

    task automatic tick(input logic v, input logic signed [W-1:0] d);
        val_in  = v;
        data_in = d;
        if (v && !rst) begin
            if (mcnt == 3) begin
                sb.push_back('{data: d - prev, at: cyc + 3});
                prev = d;
                mcnt = 0;
            end else begin
                mcnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        val_in  = 1'b1;
        data_in = 38'sd123;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_val_out", val_out, 0);
            check("rst_data_out", data_out, 0);
        end
        rst    = 1'b0;
        val_in = 1'b0;
        mcnt   = 0;
        prev   = '0;
    endtask

    int last_out = -1;
    bit space_on = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (val_out) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_data", data_out, e.data);
                check("out_latency", cyc, e.at);
            end
            if (space_on && last_out >= 0) check("out_spacing", cyc - last_out, 8);
            last_out = cyc;
        end
    end

    int def_n    = 0;
    int def_last = -1;

    always @(negedge clk) begin
        if (def_val_out) begin
            def_n++;
            if (def_n >= 5) check("def_steady", def_out, 500);
            if (def_last >= 0) check("def_period", cyc - def_last, 128);
            def_last = cyc;
        end
    end

    initial begin
        logic signed [W-1:0] big_pos;
        logic signed [W-1:0] big_neg;
        logic signed [W-1:0] i1, i2, i3;

        do_reset();

        // Ramp, valid every cycle
        for (int k = 0; k < 20; k++) tick(1'b1, W'(5 * k));
        for (int k = 0; k < 4; k++) tick(1'b0, '0);

        // Same ramp, valid on alternate cycles
        do_reset();
        space_on = 1'b1;
        last_out = -1;
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, W'(5 * k));
            tick(1'b0, 38'sd999);
        end
        for (int k = 0; k < 4; k++) tick(1'b0, '0);
        space_on = 1'b0;

        // Wrap-around across the two's complement boundary
        do_reset();
        big_pos = (38'sd1 <<< 37) - 38'sd3;
        big_neg = -(38'sd1 <<< 37) + 38'sd5;
        for (int k = 0; k < 3; k++) tick(1'b1, '0);
        tick(1'b1, big_pos);
        for (int k = 0; k < 3; k++) tick(1'b1, '0);
        tick(1'b1, big_neg);
        for (int k = 0; k < 4; k++) tick(1'b0, '0);

        // Reset mid-phase: old samples dropped, decimation phase restarts
        do_reset();
        tick(1'b1, 38'sd77);
        tick(1'b1, 38'sd78);
        do_reset();
        for (int k = 0; k < 4; k++) tick(1'b1, W'(1000 + k));
        for (int k = 0; k < 4; k++) tick(1'b0, '0);

        // Default config fed by three integrators on a DC input
        i1 = '0;
        i2 = '0;
        i3 = '0;
        for (int k = 0; k < 1024; k++) begin
            i1 = i1 + 38'sd1000;
            i2 = i2 + i1;
            i3 = i3 + i2;
            def_val  = 1'b1;
            def_data = i3;
            @(posedge clk);
            #1;
        end
        def_val = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
        end
        check("def_out_count", def_n, 8);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
